servo_angle_ramp: RTL

//  Slew-rate limiter sitting directly upstream of the servo PWM generator; drives its 8-bit angle input.

---
 rtl/servo_pkg.sv | 17 +
 rtl/servo_tick_gen.sv | 27 ++
 rtl/servo_angle_ramp.sv | 97 +++++++++
 3 files changed

// File: rtl/servo_pkg.sv
// Shared definitions for the servo angle path: angle limits, widths, frame timing and FSM states.
package servo_pkg;

  localparam int unsigned ANGLE_MAX    = 180;
  localparam int unsigned ANGLE_W      = 8;
  localparam int unsigned CLK_HZ       = 50_000_000;
  localparam int unsigned FRAME_CYCLES = 1_000_000;

  typedef logic [ANGLE_W-1:0] angle_t;

  typedef enum logic {IDLE, RAMP} ramp_state_e;

  function automatic angle_t clamp_angle(input angle_t a);
    return (a > angle_t'(ANGLE_MAX)) ? angle_t'(ANGLE_MAX) : a;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running frame counter; pulses tick for one clock every TICK_CYCLES clocks.
module servo_tick_gen #(
  parameter int unsigned TICK_CYCLES = servo_pkg::FRAME_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_CYCLES - 1);

  logic [CntW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == CntMax) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CntMax);

endmodule

// File: rtl/servo_angle_ramp.sv
// Slew-rate limiter for the servo PWM angle: accepts target commands and steps the output angle
// toward the target by STEP_DEG once per frame tick.
module servo_angle_ramp
  import servo_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = FRAME_CYCLES,
  parameter int unsigned STEP_DEG    = 2,
  parameter int unsigned INIT_ANGLE  = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_angle,
  output logic [7:0] angle,
  output logic       busy,
  output logic       done,
  output logic       clamped
);

  if (STEP_DEG < 1 || STEP_DEG > ANGLE_MAX) begin : g_bad_step
    $error("STEP_DEG must be in 1..180");
  end
  if (INIT_ANGLE > ANGLE_MAX) begin : g_bad_init
    $error("INIT_ANGLE must be <= 180");
  end
  if (TICK_CYCLES < 2) begin : g_bad_tick
    $error("TICK_CYCLES must be >= 2");
  end

  localparam angle_t Step = angle_t'(STEP_DEG);
  localparam angle_t Init = angle_t'(INIT_ANGLE);

  ramp_state_e state;
  angle_t      target;
  angle_t      cmd_tgt;
  angle_t      next_angle;
  logic [8:0]  diff;
  logic        tick;
  logic        accept;

  servo_tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  // Ready in every non-reset cycle, so it simply follows rst_n.
  assign cmd_ready = rst_n;
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    cmd_tgt    = clamp_angle(cmd_angle);
    diff       = (target >= angle) ? ({1'b0, target} - {1'b0, angle})
                                   : ({1'b0, angle} - {1'b0, target});
    next_angle = (target > angle) ? angle + Step : angle - Step;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      angle   <= Init;
      target  <= Init;
      busy    <= 1'b0;
      done    <= 1'b0;
      clamped <= 1'b0;
    end else begin
      done    <= 1'b0;
      clamped <= 1'b0;
      if (accept) begin
        // An accept takes priority over a coincident tick: no step this frame.
        target  <= cmd_tgt;
        clamped <= (cmd_angle > angle_t'(ANGLE_MAX));
        if (cmd_tgt == angle) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= RAMP;
          busy  <= 1'b1;
        end
      end else if (tick && state == RAMP) begin
        if (diff <= {1'b0, Step}) begin
          angle <= target;
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          angle <= next_angle;
        end
      end
    end
  end

endmodule
